bk_sysregs: RTL and testbench
=============================

Name: bk_sysregs

Overview:
Parametrised register-space responder for the BK core. It decodes the 177600–177776 (octal) window on the CPU bus and generates RPLY with a configurable wait count. It adds a bus-error timeout for unmapped addresses and a DEPTH-deep keyboard FIFO. It drives the keyboard VIRQ and supplies the interrupt vector during IAKO.

Parameters:
KBD_DEPTH, 4, keyboard FIFO entries; power of two, >=2
REPLY_WAIT, 1, ce-cycles from strobe decode to rply assertion (>=1)
TIMEOUT, 16, ce-cycles before bus_error on an unmapped register address
ROLL_RESET, 16'o001330, reset value of the scroll register
INIT_HI, 8'o200, constant high byte returned by register 116

Ports:
clk  in  1  core clock
reset_n  in  1  reset, synchronous, active-low
ce  in  1  core clock enable; all state advances only when ce=1 (reset excepted)
adr  in  16  CPU address
data_i  in  16  CPU write data; odd-byte writes carry the byte on [15:8]
data_o  out  16  read data / vector
din  in  1  CPU read strobe
dout  in  1  CPU write strobe
wtbt  in  1  byte access
iako  in  1  interrupt acknowledge (with din)
cpu_pri  in  3  PSW priority [7:5]
rply  out  1  reply to CPU
bus_error  out  1  unmapped-register timeout
virq  out  1  vectored interrupt request
kbd_strobe  in  1  one-cycle key-arrival pulse
kbd_code  in  8  key code
kbd_ar2  in  1  AR2 modifier for that key
stopkey, keydown, tape_in  in  1 each  STOP key, key held, tape input bit
tape_out  out  1  tape/sound bit
roll_out  out  8  scroll offset
full_screen_o  out  1  roll bit 9
spi_wren  out  1  one-ce pulse on write to 114
spi_do  out  8  SPI byte out
spi_di  in  8  SPI byte in
spi_dsr  in  1  SPI ready

Behaviour:
- Reset (reset_n=0 at clk edge):
  - rply=0, bus_error=0, virq=0, tape_out=0, spi_wren=0, spi_do=0.
  - FIFO empty, overflow=0, int_dis=0, stop_latch=0, roll=ROLL_RESET.
  - Any in-flight transaction is abandoned.
- Selection: sel = adr[15:7]==9'b111111111 and (din|dout|iako&din). Mapped offsets adr[6:0] (octal) are 060, 062, 064, 114, 116; all others are unmapped.
- Transaction FSM: IDLE -> WAIT -> REPLY -> IDLE.
  - IDLE -> WAIT on sel (mapped) or iako&din; wait counter loaded with REPLY_WAIT.
  - WAIT decrements per ce. At 0: go to REPLY, rply=1, and perform the side effect (write or pop) exactly once.
  - REPLY holds rply until din and dout are both 0, then returns to IDLE.
  - Unmapped: IDLE -> TOUT and count TIMEOUT ce-cycles. At expiry, bus_error=1 until the strobes drop. rply is never asserted.
  - A strobe drop in WAIT or TOUT returns to IDLE with no side effect.
- Register reads (data_o is valid while rply=1):
  - 060: {8'0, fifo_nonempty, int_dis, overflow, 5'0}.
  - 062: {8'0, head code}, or 0 if empty. Completion pops the FIFO when non-empty.
  - 064: roll[15:0]; only bits 9 and 7:0 are stored, the rest read 0.
  - 114: {~spi_dsr, 7'0, spi_di}.
  - 116: {INIT_HI, 1, ~keydown, tape_in, 0, 0, stop_latch, 0, 0}. Completion clears stop_latch.
- Byte reads: wtbt & adr[0] returns {8'0, reg[15:8]}; wtbt & ~adr[0] returns {8'0, reg[7:0]}.
- Writes apply at REPLY entry:
  - Word write updates all fields.
  - Even-byte write updates only fields in [7:0].
  - Odd-byte write updates only fields in [15:8], sourced from data_i[15:8].
- Write fields:
  - 060: int_dis<=d[6]; d[5]=1 clears overflow.
  - 064: roll[9], roll[7:0].
  - 114: spi_do<=d[7:0] and spi_wren=1 for one ce-cycle.
  - 116: tape_out<=d[6].
  - 062 writes are ignored but still replied.
- Keyboard FIFO: each entry is {ar2, code}.
  - kbd_strobe pushes. A push while full is dropped and sets overflow (sticky).
  - Push and pop in the same ce-cycle: both occur and the count is unchanged. When empty, only the push occurs.
  - Pointers wrap modulo KBD_DEPTH. The count range is 0..KBD_DEPTH.
- stop_latch: set while stopkey=1. Set wins over a simultaneous clear.
- Interrupt:
  - virq = fifo_nonempty & ~int_dis & (cpu_pri==0), registered with one ce-cycle latency.
  - iako&din returns vector 16'o000274 if the head ar2=1, else 16'o000060. The vector read does not pop.
- roll_out=roll[7:0]; full_screen_o=roll[9].

Test Plan:
- Reset, then word read 177664 with REPLY_WAIT=1 -> rply 1 ce after din, data_o=16'o001330, full_screen_o=1, roll_out=8'o330.
- Push codes 101, 102 (ar2=0) -> 177660 reads 16'o000200. Read 177662 twice returns 101 then 102; a third read returns 177660=0. virq is 1 while non-empty and 0 after the second pop.
- With KBD_DEPTH=4, push 5 keys -> 5th dropped and 177660 bit5=1. Write 177660=16'o000040 -> bit5 clears while the FIFO is still full. Push and pop in the same ce-cycle when full -> count stays 4.
- Push a key with ar2=1, cpu_pri=0, iako&din -> data_o=16'o000274 and rply; the FIFO is not popped. cpu_pri=3 -> virq=0.
- din at 177700 with TIMEOUT=16 -> rply stays 0 and bus_error=1 after 16 ce-cycles. Dropping din clears it.
- Byte write 177665=8'o002 (data_i[15:8]) -> full_screen_o=1 and roll_out unchanged. Write 177714=16'o125 -> spi_do=8'o125 with a single spi_wren pulse. Assert reset_n=0 mid-WAIT -> rply=0 and no write occurs.

Source files
------------

// File: rtl/bk_sysregs.sv
// rtl/bk_sysregs.sv - BK 177600-177776 register window: reply timing, bus timeout, keyboard FIFO, VIRQ
module bk_sysregs #(
    parameter int          KBD_DEPTH  = 4,
    parameter int          REPLY_WAIT = 1,
    parameter int          TIMEOUT    = 16,
    parameter logic [15:0] ROLL_RESET = 16'o001330,
    parameter logic [7:0]  INIT_HI    = 8'o200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [15:0] adr,
    input  logic [15:0] data_i,
    output logic [15:0] data_o,
    input  logic        din,
    input  logic        dout,
    input  logic        wtbt,
    input  logic        iako,
    input  logic [2:0]  cpu_pri,
    output logic        rply,
    output logic        bus_error,
    output logic        virq,
    input  logic        kbd_strobe,
    input  logic [7:0]  kbd_code,
    input  logic        kbd_ar2,
    input  logic        stopkey,
    input  logic        keydown,
    input  logic        tape_in,
    output logic        tape_out,
    output logic [7:0]  roll_out,
    output logic        full_screen_o,
    output logic        spi_wren,
    output logic [7:0]  spi_do,
    input  logic [7:0]  spi_di,
    input  logic        spi_dsr
);
    localparam int PW      = (KBD_DEPTH > 1) ? $clog2(KBD_DEPTH) : 1;
    localparam int CW      = PW + 1;
    localparam int CNT_MAX = (REPLY_WAIT > TIMEOUT) ? REPLY_WAIT : TIMEOUT;
    localparam int TW      = $clog2(CNT_MAX + 1);

    localparam logic [6:0] OFF_KSR  = 7'o060;
    localparam logic [6:0] OFF_KDR  = 7'o062;
    localparam logic [6:0] OFF_ROLL = 7'o064;
    localparam logic [6:0] OFF_SPI  = 7'o114;
    localparam logic [6:0] OFF_SYS  = 7'o116;
    localparam logic [CW-1:0] FIFO_FULL = CW'(KBD_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPLY, S_TOUT} state_t;

    state_t        state;
    logic [TW-1:0] cnt;
    logic [6:0]    t_off;
    logic          t_byte, t_odd, t_write, t_iako;

    logic [8:0]    fifo_mem [KBD_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          overflow, int_dis, stop_latch, roll9;
    logic [7:0]    roll_lo;

    logic          strobe, vec_req, in_window, mapped;
    logic          fifo_nonempty, fifo_full;
    logic          fire, do_wr, do_rd, lo_en, hi_en;
    logic          push, pop, push_ok;
    logic [6:0]    cur_off;
    logic [8:0]    head;
    logic [15:0]   reg_val, rd_data;
    logic          unused_ok;

    assign strobe        = din | dout;
    assign vec_req       = iako & din;
    assign in_window     = adr[15:7] == 9'h1FF;
    assign cur_off       = {adr[6:1], 1'b0};
    assign mapped        = cur_off inside {OFF_KSR, OFF_KDR, OFF_ROLL, OFF_SPI, OFF_SYS};
    assign fifo_nonempty = count != '0;
    assign fifo_full     = count == FIFO_FULL;
    assign head          = fifo_mem[rd_ptr];

    // fire marks the single ce-cycle that enters REPLY; every side effect keys off it
    assign fire    = ce & (state == S_WAIT) & strobe & (cnt <= TW'(1));
    assign do_wr   = fire & t_write & ~t_iako;
    assign do_rd   = fire & ~t_write & ~t_iako;
    assign lo_en   = ~t_byte | ~t_odd;
    assign hi_en   = ~t_byte | t_odd;
    assign push    = ce & kbd_strobe;
    assign pop     = do_rd & (t_off == OFF_KDR) & fifo_nonempty;
    assign push_ok = push & (~fifo_full | pop);

    assign roll_out      = roll_lo;
    assign full_screen_o = roll9;
    assign unused_ok     = ^{data_i[15:10], data_i[8]};

    always_comb begin
        reg_val = '0;
        case (t_off)
            OFF_KSR:  reg_val = {8'h00, fifo_nonempty, int_dis, overflow, 5'b0};
            OFF_KDR:  reg_val = fifo_nonempty ? {8'h00, head[7:0]} : 16'h0000;
            OFF_ROLL: reg_val = {6'b0, roll9, 1'b0, roll_lo};
            OFF_SPI:  reg_val = {~spi_dsr, 7'b0, spi_di};
            OFF_SYS:  reg_val = {INIT_HI, 1'b1, ~keydown, tape_in, 2'b00, stop_latch, 2'b00};
            default:  reg_val = '0;
        endcase
        rd_data = reg_val;
        if (t_iako)
            rd_data = (fifo_nonempty & head[8]) ? 16'o000274 : 16'o000060;
        else if (t_byte)
            rd_data = {8'h00, t_odd ? reg_val[15:8] : reg_val[7:0]};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rply      <= 1'b0;
            bus_error <= 1'b0;
            data_o    <= '0;
            t_off     <= '0;
            t_byte    <= 1'b0;
            t_odd     <= 1'b0;
            t_write   <= 1'b0;
            t_iako    <= 1'b0;
        end else if (ce) begin
            case (state)
                S_IDLE: begin
                    if (vec_req) begin
                        state   <= S_WAIT;
                        cnt     <= TW'(REPLY_WAIT);
                        t_iako  <= 1'b1;
                        t_write <= 1'b0;
                        t_byte  <= 1'b0;
                        t_odd   <= 1'b0;
                        t_off   <= '0;
                    end else if (in_window && strobe) begin
                        t_iako  <= 1'b0;
                        t_write <= dout;
                        t_byte  <= wtbt;
                        t_odd   <= adr[0];
                        t_off   <= cur_off;
                        if (mapped) begin
                            state <= S_WAIT;
                            cnt   <= TW'(REPLY_WAIT);
                        end else begin
                            state <= S_TOUT;
                            cnt   <= TW'(TIMEOUT);
                        end
                    end
                end
                S_WAIT: begin
                    if (!strobe) begin
                        state <= S_IDLE;
                    end else if (cnt <= TW'(1)) begin
                        state  <= S_REPLY;
                        rply   <= 1'b1;
                        data_o <= rd_data;
                    end else begin
                        cnt <= cnt - TW'(1);
                    end
                end
                S_REPLY: begin
                    if (!strobe) begin
                        state  <= S_IDLE;
                        rply   <= 1'b0;
                        data_o <= '0;
                    end
                end
                S_TOUT: begin
                    if (!strobe) begin
                        state     <= S_IDLE;
                        bus_error <= 1'b0;
                    end else if (cnt <= TW'(1)) begin
                        bus_error <= 1'b1;
                    end else begin
                        cnt <= cnt - TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= {kbd_ar2, kbd_code};
    end

    // A push into a full FIFO survives only when a pop frees the slot in the same cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (ce) begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)
                count <= count + CW'(1);
            else if (pop && !push_ok)
                count <= count - CW'(1);
            if (push && !push_ok)
                overflow <= 1'b1;
            else if (do_wr && lo_en && t_off == OFF_KSR && data_i[5])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            int_dis    <= 1'b0;
            stop_latch <= 1'b0;
            roll9      <= ROLL_RESET[9];
            roll_lo    <= ROLL_RESET[7:0];
            tape_out   <= 1'b0;
            spi_do     <= '0;
            spi_wren   <= 1'b0;
            virq       <= 1'b0;
        end else if (ce) begin
            spi_wren <= 1'b0;
            virq     <= fifo_nonempty & ~int_dis & (cpu_pri == 3'd0);
            if (stopkey)
                stop_latch <= 1'b1;
            else if (do_rd && t_off == OFF_SYS)
                stop_latch <= 1'b0;
            if (do_wr) begin
                case (t_off)
                    OFF_KSR: if (lo_en) int_dis <= data_i[6];
                    OFF_ROLL: begin
                        if (hi_en) roll9   <= data_i[9];
                        if (lo_en) roll_lo <= data_i[7:0];
                    end
                    OFF_SPI: if (lo_en) begin
                        spi_do   <= data_i[7:0];
                        spi_wren <= 1'b1;
                    end
                    OFF_SYS: if (lo_en) tape_out <= data_i[6];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bk_sysregs.sv
// tb/tb_bk_sysregs.sv - randomized self-checking bench for bk_sysregs against a register-level model
module tb_bk_sysregs;
    localparam int D  = 4;
    localparam int RW = 1;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n, ce, din, dout, wtbt, iako;
    logic [15:0] adr, data_i, data_o;
    logic [2:0]  cpu_pri;
    logic        rply, bus_error, virq;
    logic        kbd_strobe, kbd_ar2, stopkey, keydown, tape_in, tape_out;
    logic [7:0]  kbd_code, roll_out, spi_do, spi_di;
    logic        full_screen_o, spi_wren, spi_dsr;

    always #5 clk = ~clk;

    bk_sysregs #(.KBD_DEPTH(D), .REPLY_WAIT(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .adr(adr), .data_i(data_i), .data_o(data_o),
        .din(din), .dout(dout), .wtbt(wtbt), .iako(iako), .cpu_pri(cpu_pri),
        .rply(rply), .bus_error(bus_error), .virq(virq),
        .kbd_strobe(kbd_strobe), .kbd_code(kbd_code), .kbd_ar2(kbd_ar2),
        .stopkey(stopkey), .keydown(keydown), .tape_in(tape_in), .tape_out(tape_out),
        .roll_out(roll_out), .full_screen_o(full_screen_o),
        .spi_wren(spi_wren), .spi_do(spi_do), .spi_di(spi_di), .spi_dsr(spi_dsr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int wren_cnt = 0;

    // reference model
    logic [8:0] q[$];
    bit         m_ovf, m_intdis, m_r9, m_tape, m_stop;
    logic [7:0] m_rlo, m_spi;
    logic [6:0] offs [5] = '{7'o060, 7'o062, 7'o064, 7'o114, 7'o116};

    always @(posedge clk) begin
        #1;
        if (spi_wren === 1'b1) wren_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_intdis = 0; m_stop = 0; m_tape = 0;
        m_r9 = 1'b1; m_rlo = 8'o330; m_spi = 8'h00;
    endtask

    function automatic logic [15:0] exp_reg(input logic [6:0] off);
        case (off)
            7'o060:  return {8'h00, (q.size() != 0), m_intdis, m_ovf, 5'b0};
            7'o062:  return (q.size() != 0) ? {8'h00, q[0][7:0]} : 16'h0000;
            7'o064:  return {6'b0, m_r9, 1'b0, m_rlo};
            7'o114:  return {~spi_dsr, 7'b0, spi_di};
            7'o116:  return {8'o200, 1'b1, ~keydown, tape_in, 2'b00, m_stop, 2'b00};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic do_access(input logic [15:0] a, input bit wr, input bit bt,
                             input logic [15:0] d, input string nm);
        logic [15:0] r, e, rd;
        logic [6:0]  off;
        bit          lo, hi, ev;
        int          lat;
        off = {a[6:1], 1'b0};
        r   = exp_reg(off);
        e   = bt ? {8'h00, (a[0] ? r[15:8] : r[7:0])} : r;
        @(negedge clk);
        adr = a; wtbt = bt; data_i = d; din = !wr; dout = wr;
        lat = 0;
        while (rply !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        rd = data_o;
        n_checks++;
        if (lat != RW + 1) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", nm, lat, RW + 1);
        end
        if (!wr) begin
            n_checks++;
            if (rd !== e) begin
                n_fail++;
                $display("FAIL %s read adr=%o: got %o want %o", nm, a, rd, e);
            end
        end
        din = 0; dout = 0; wtbt = 0;
        @(negedge clk);
        n_checks++;
        if (rply !== 1'b0) begin
            n_fail++;
            $display("FAIL %s rply release: got %b want 0", nm, rply);
        end
        lo = !bt || !a[0];
        hi = !bt || a[0];
        if (!wr) begin
            if (off == 7'o062 && q.size() != 0) q.delete(0);
            if (off == 7'o116) m_stop = 0;
        end else begin
            case (off)
                7'o060: if (lo) begin m_intdis = d[6]; if (d[5]) m_ovf = 0; end
                7'o064: begin if (hi) m_r9 = d[9]; if (lo) m_rlo = d[7:0]; end
                7'o114: if (lo) m_spi = d[7:0];
                7'o116: if (lo) m_tape = d[6];
                default: ;
            endcase
        end
        n_checks++;
        if ({full_screen_o, roll_out, tape_out, spi_do} !== {m_r9, m_rlo, m_tape, m_spi}) begin
            n_fail++;
            $display("FAIL %s outputs fs/roll/tape/spi: got %b/%o/%b/%o want %b/%o/%b/%o", nm,
                     full_screen_o, roll_out, tape_out, spi_do, m_r9, m_rlo, m_tape, m_spi);
        end
        ev = (q.size() != 0) && !m_intdis && (cpu_pri == 3'd0);
        n_checks++;
        if (virq !== ev) begin
            n_fail++;
            $display("FAIL %s virq: got %b want %b", nm, virq, ev);
        end
    endtask

    task automatic push_key(input logic [7:0] c, input bit a2);
        bit ev;
        @(negedge clk);
        kbd_strobe = 1; kbd_code = c; kbd_ar2 = a2;
        @(negedge clk);
        kbd_strobe = 0;
        if (q.size() < D) q.push_back({a2, c});
        else m_ovf = 1;
        @(negedge clk);
        ev = (q.size() != 0) && !m_intdis && (cpu_pri == 3'd0);
        n_checks++;
        if (virq !== ev) begin
            n_fail++;
            $display("FAIL push virq: got %b want %b", virq, ev);
        end
    endtask

    task automatic do_vector(input string nm);
        logic [15:0] e;
        int lat;
        e = q[0][8] ? 16'o000274 : 16'o000060;
        @(negedge clk);
        adr = 16'($urandom); iako = 1; din = 1;
        lat = 0;
        while (rply !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (rply !== 1'b1 || data_o !== e) begin
            n_fail++;
            $display("FAIL %s vector: rply=%b data=%o want %o", nm, rply, data_o, e);
        end
        din = 0; iako = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 0; ce = 1; din = 0; dout = 0; wtbt = 0; iako = 0; cpu_pri = 0;
        adr = 0; data_i = 0; kbd_strobe = 0; kbd_code = 0; kbd_ar2 = 0;
        stopkey = 0; keydown = 0; tape_in = 0; spi_di = 0; spi_dsr = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        model_reset();
        @(negedge clk);
        n_checks++;
        if ({rply, bus_error, virq, tape_out, spi_wren} !== 5'b0 || spi_do !== 8'h00) begin
            n_fail++;
            $display("FAIL reset flags: got %b%b%b%b%b spi_do=%o want 0", rply, bus_error, virq,
                     tape_out, spi_wren, spi_do);
        end
        n_checks++;
        if (roll_out !== 8'o330 || full_screen_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset roll: got %o/%b want 330/1", roll_out, full_screen_o);
        end
    endtask

    task automatic test_roll_read();
        do_access(16'o177664, 0, 0, 16'h0, "roll_read");
    endtask

    task automatic test_fifo_basic();
        cpu_pri = 0;
        push_key(8'o101, 0);
        push_key(8'o102, 0);
        do_access(16'o177660, 0, 0, 16'h0, "ksr_two");
        do_access(16'o177662, 0, 0, 16'h0, "kdr_first");
        do_access(16'o177662, 0, 0, 16'h0, "kdr_second");
        do_access(16'o177662, 0, 0, 16'h0, "kdr_empty");
        do_access(16'o177660, 0, 0, 16'h0, "ksr_empty");
    endtask

    task automatic test_overflow();
        logic [7:0] c;
        for (int i = 0; i < D + 1; i++) push_key(8'(8'o140 + i), 0);
        do_access(16'o177660, 0, 0, 16'h0, "ksr_ovf");
        do_access(16'o177660, 1, 0, 16'o000040, "ksr_clr");
        do_access(16'o177660, 0, 0, 16'h0, "ksr_cleared");
        c = 8'o177;
        @(negedge clk);
        adr = 16'o177662; din = 1; wtbt = 0;
        repeat (RW) @(negedge clk);
        kbd_strobe = 1; kbd_code = c; kbd_ar2 = 0;
        @(negedge clk);
        kbd_strobe = 0;
        n_checks++;
        if (rply !== 1'b1 || data_o !== {8'h00, q[0][7:0]}) begin
            n_fail++;
            $display("FAIL pushpop read: rply=%b data=%o want %o", rply, data_o, q[0][7:0]);
        end
        q.delete(0);
        q.push_back({1'b0, c});
        din = 0;
        @(negedge clk);
        do_access(16'o177660, 0, 0, 16'h0, "ksr_pushpop");
        for (int i = 0; i < D; i++) do_access(16'o177662, 0, 0, 16'h0, "drain");
        do_access(16'o177662, 0, 0, 16'h0, "drain_empty");
    endtask

    task automatic test_vector();
        cpu_pri = 0;
        push_key(8'o123, 1);
        do_vector("vec_ar2");
        do_access(16'o177662, 0, 0, 16'h0, "vec_nopop");
        push_key(8'o124, 0);
        do_vector("vec_plain");
        cpu_pri = 3;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (virq !== 1'b0) begin
            n_fail++;
            $display("FAIL virq masked: got %b want 0", virq);
        end
        cpu_pri = 0;
        do_access(16'o177662, 0, 0, 16'h0, "vec_drain");
    endtask

    task automatic test_timeout();
        int lat;
        bit seen;
        @(negedge clk);
        adr = 16'o177700; din = 1; wtbt = 0;
        lat = 0; seen = 0;
        while (bus_error !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (rply === 1'b1) seen = 1;
        end
        n_checks++;
        if (lat != TO + 1) begin
            n_fail++;
            $display("FAIL timeout latency: got %0d want %0d", lat, TO + 1);
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL timeout rply: got 1 want 0");
        end
        din = 0;
        @(negedge clk);
        n_checks++;
        if (bus_error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout release: got %b want 0", bus_error);
        end
    endtask

    task automatic test_byte_write();
        do_access(16'o177665, 1, 1, 16'o000000, "roll_hi_clr");
        do_access(16'o177665, 1, 1, 16'o001000, "roll_hi_set");
        do_access(16'o177664, 1, 1, 16'o000055, "roll_lo_byte");
        do_access(16'o177665, 0, 1, 16'h0, "roll_hi_read");
        do_access(16'o177664, 0, 1, 16'h0, "roll_lo_read");
    endtask

    task automatic test_spi();
        int w0;
        w0 = wren_cnt;
        do_access(16'o177714, 1, 0, 16'o000125, "spi_write");
        n_checks++;
        if (wren_cnt - w0 != 1) begin
            n_fail++;
            $display("FAIL spi_wren pulses: got %0d want 1", wren_cnt - w0);
        end
    endtask

    task automatic test_strobe_drop();
        do_access(16'o177664, 1, 0, 16'o001377, "roll_set");
        @(negedge clk);
        adr = 16'o177664; dout = 1; data_i = 16'h0000; wtbt = 0;
        @(negedge clk);
        dout = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (roll_out !== m_rlo || full_screen_o !== m_r9 || rply !== 1'b0) begin
            n_fail++;
            $display("FAIL strobe_drop: roll=%o fs=%b rply=%b want %o %b 0", roll_out,
                     full_screen_o, rply, m_rlo, m_r9);
        end
    endtask

    task automatic test_stop();
        @(negedge clk);
        stopkey = 1;
        @(negedge clk);
        stopkey = 0;
        m_stop = 1;
        do_access(16'o177716, 0, 0, 16'h0, "stop_set");
        do_access(16'o177716, 0, 0, 16'h0, "stop_cleared");
    endtask

    task automatic test_ce_gating();
        logic [15:0] e;
        int lat;
        e = exp_reg(7'o064);
        @(negedge clk);
        ce = 0; adr = 16'o177664; din = 1; wtbt = 0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (rply !== 1'b0) begin
            n_fail++;
            $display("FAIL ce_gating held: rply=%b want 0", rply);
        end
        ce = 1;
        lat = 0;
        while (rply !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != RW + 1 || data_o !== e) begin
            n_fail++;
            $display("FAIL ce_gating reply: lat=%0d data=%o want %0d %o", lat, data_o, RW + 1, e);
        end
        din = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] a;
        bit bt;
        bit ev;
        for (int i = 0; i < 300; i++) begin
            keydown = 1'($urandom); tape_in = 1'($urandom);
            spi_di = 8'($urandom); spi_dsr = 1'($urandom);
            bt = 1'($urandom);
            a = 16'o177600 | 16'(offs[$urandom_range(0, 4)]) | 16'(bt & 1'($urandom));
            case ($urandom_range(0, 4))
                0: push_key(8'($urandom), 1'($urandom));
                1: do_access(a, 0, bt, 16'h0, "rnd_read");
                2: do_access(a, 1, bt, 16'($urandom), "rnd_write");
                3: begin
                    cpu_pri = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
                    @(negedge clk);
                    ev = (q.size() != 0) && !m_intdis && (cpu_pri == 3'd0);
                    n_checks++;
                    if (virq !== ev) begin
                        n_fail++;
                        $display("FAIL rnd virq pri=%0d: got %b want %b", cpu_pri, virq, ev);
                    end
                end
                default: if (q.size() != 0) do_vector("rnd_vector");
            endcase
        end
    endtask

    task automatic test_reset_midwait();
        int w0;
        do_access(16'o177714, 1, 0, 16'o000252, "spi_pre");
        w0 = wren_cnt;
        @(negedge clk);
        adr = 16'o177714; dout = 1; data_i = 16'o000125; wtbt = 0;
        @(negedge clk);
        reset_n = 0;
        @(negedge clk);
        n_checks++;
        if (rply !== 1'b0 || spi_do !== 8'h00 || wren_cnt != w0) begin
            n_fail++;
            $display("FAIL reset_midwait: rply=%b spi_do=%o pulses=%0d want 0 0 0", rply, spi_do,
                     wren_cnt - w0);
        end
        dout = 0; reset_n = 1;
        model_reset();
        @(negedge clk);
        do_access(16'o177664, 0, 0, 16'h0, "post_reset_roll");
    endtask

    initial begin
        test_reset();
        test_roll_read();
        test_fifo_basic();
        test_overflow();
        test_vector();
        test_timeout();
        test_byte_write();
        test_spi();
        test_strobe_drop();
        test_stop();
        test_ce_gating();
        test_random();
        test_reset_midwait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
